button_press_event: RTL and testbench

- Upstream feeder for uart_transmitter.
- Synchronises and debounces a raw push-button input and detects debounced presses (0->1 transitions).
- Queues presses in a saturating pending counter and drives the transmitter's data_ready/busy handshake so that each queued press triggers exactly one UART frame.

---
 rtl/button_press_event.sv | 109 ++++++++++
 tb/tb_button_press_event.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/button_press_event.sv
// Button synchroniser, debouncer and press queue that feeds uart_transmitter.
// Each queued press is turned into exactly one data_ready/busy handshake.
module button_press_event #(
    parameter int DEBOUNCE_CYCLES = 1250000,
    parameter int PENDING_MAX     = 3,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                             sysclk,
    input  logic                             rst_n,
    input  logic                             btn,
    input  logic                             busy,
    output logic                             data_ready,
    output logic                             btn_debounced,
    output logic [$clog2(PENDING_MAX+1)-1:0] pending,
    output logic [COUNT_WIDTH-1:0]           press_count,
    output logic                             overflow
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int PW = $clog2(PENDING_MAX + 1);

    logic                   s1_q;
    logic                   s2_q;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   deb_q;
    logic                   deb_d;
    logic [PW-1:0]          pend_q;
    logic [PW-1:0]          pend_d;
    logic                   dr_q;
    logic                   dr_d;
    logic [COUNT_WIDTH-1:0] pcnt_q;
    logic [COUNT_WIDTH-1:0] pcnt_d;
    logic                   ovf_q;
    logic                   ovf_d;
    logic                   differ;
    logic                   flip;
    logic                   press;
    logic                   accept;

    assign differ = (s2_q != deb_q);
    assign flip   = differ && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
    assign press  = flip && s2_q;
    assign accept = dr_q && !busy;

    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        if (!differ || flip) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        if (flip) begin
            deb_d = s2_q;
        end
    end

    // A press and an accept on the same edge cancel, so a full queue cannot overflow then
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        pcnt_d = pcnt_q;
        if (press) begin
            pcnt_d = pcnt_q + COUNT_WIDTH'(1);
        end
        unique case ({press, accept})
            2'b10: begin
                if (pend_q < PW'(PENDING_MAX)) begin
                    pend_d = pend_q + PW'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end
            2'b01:   pend_d = pend_q - PW'(1);
            default: pend_d = pend_q;
        endcase
        dr_d = accept ? 1'b0 : (pend_d != '0);
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            cnt_q  <= '0;
            deb_q  <= 1'b0;
            pend_q <= '0;
            dr_q   <= 1'b0;
            pcnt_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            s1_q   <= btn;
            s2_q   <= s1_q;
            cnt_q  <= cnt_d;
            deb_q  <= deb_d;
            pend_q <= pend_d;
            dr_q   <= dr_d;
            pcnt_q <= pcnt_d;
            ovf_q  <= ovf_d;
        end
    end

    assign data_ready    = dr_q;
    assign btn_debounced = deb_q;
    assign pending       = pend_q;
    assign press_count   = pcnt_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_button_press_event.sv
// Randomised bench for button_press_event against a sample-window reference model.
// Directed phases cover latency, glitch rejection, full-queue coincidence and overflow.
module tb_button_press_event;

    localparam int DC   = 4;
    localparam int PMAX = 3;
    localparam int CWID = 16;

    logic        sysclk;
    logic        rst_n;
    logic        btn;
    logic        busy;
    logic        data_ready;
    logic        btn_debounced;
    logic [1:0]  pending;
    logic [15:0] press_count;
    logic        overflow;

    int n_checks;
    int n_errors;

    bit q_hist[$];
    bit q_win[$];
    bit m_deb;
    int m_pend;
    bit m_dr;
    int m_pc;
    bit m_ovf;

    button_press_event #(
        .DEBOUNCE_CYCLES(DC),
        .PENDING_MAX    (PMAX),
        .COUNT_WIDTH    (CWID)
    ) dut (
        .sysclk       (sysclk),
        .rst_n        (rst_n),
        .btn          (btn),
        .busy         (busy),
        .data_ready   (data_ready),
        .btn_debounced(btn_debounced),
        .pending      (pending),
        .press_count  (press_count),
        .overflow     (overflow)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_hist = {1'b0, 1'b0};
        q_win  = {};
        m_deb  = 1'b0;
        m_pend = 0;
        m_dr   = 1'b0;
        m_pc   = 0;
        m_ovf  = 1'b0;
    endtask

    // The debounced level flips once the last DC synchronised samples all disagree with it
    task automatic model_edge(input bit b, input bit bz);
        bit din;
        bit flip;
        bit press;
        bit acc;
        din = q_hist.pop_front();
        q_hist.push_back(b);
        q_win.push_back(din);
        if (q_win.size() > DC) void'(q_win.pop_front());
        flip = (q_win.size() == DC);
        foreach (q_win[i]) if (q_win[i] == m_deb) flip = 1'b0;
        press = flip && din;
        if (flip) m_deb = din;
        acc = m_dr && !bz;
        if (press) m_pc = (m_pc + 1) % (1 << CWID);
        if (press && !acc) begin
            if (m_pend < PMAX) m_pend++;
            else m_ovf = 1'b1;
        end else if (!press && acc) begin
            m_pend--;
        end
        m_dr = acc ? 1'b0 : (m_pend != 0);
    endtask

    task automatic compare_all();
        chk("btn_debounced", 32'(btn_debounced), 32'(m_deb));
        chk("pending", 32'(pending), 32'(m_pend));
        chk("data_ready", 32'(data_ready), 32'(m_dr));
        chk("press_count", 32'(press_count), 32'(m_pc));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic step(input bit b, input bit bz);
        btn  = b;
        busy = bz;
        @(posedge sysclk);
        model_edge(b, bz);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        @(posedge sysclk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_dr", 32'(data_ready), 32'd0);
        chk("rst_deb", 32'(btn_debounced), 32'd0);
        chk("rst_pend", 32'(pending), 32'd0);
        chk("rst_pc", 32'(press_count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        model_reset();
        repeat (2) @(posedge sysclk);
        #2 rst_n = 1'b1;
    endtask

    task automatic clean_press(input bit bz);
        repeat (8) step(1'b1, bz);
        repeat (8) step(1'b0, bz);
    endtask

    initial begin
        int lvl;
        int len;
        int blen;
        bit bz;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        btn   = 1'b0;
        busy  = 1'b0;
        model_reset();
        repeat (2) @(posedge sysclk);
        #2;
        chk("init_dr", 32'(data_ready), 32'd0);
        chk("init_pend", 32'(pending), 32'd0);
        rst_n = 1'b1;

        // Press latency: visible after edge DC+2, accepted on the next edge
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0);
            if (i == 5) chk("lat_deb_early", 32'(btn_debounced), 32'd0);
            if (i == 6) begin
                chk("lat_deb", 32'(btn_debounced), 32'd1);
                chk("lat_pend", 32'(pending), 32'd1);
                chk("lat_dr", 32'(data_ready), 32'd1);
            end
            if (i == 7) begin
                chk("acc_pend", 32'(pending), 32'd0);
                chk("acc_dr", 32'(data_ready), 32'd0);
                chk("acc_pc", 32'(press_count), 32'd1);
            end
        end
        repeat (8) step(1'b0, 1'b0);

        // Short pulses never survive the debouncer
        repeat (5) begin
            repeat (3) step(1'b1, 1'b0);
            repeat (3) step(1'b0, 1'b0);
        end
        repeat (6) step(1'b0, 1'b0);
        chk("glitch_pc", 32'(press_count), 32'd1);
        chk("glitch_deb", 32'(btn_debounced), 32'd0);

        // Press flip coinciding with an accept while the queue is full
        do_reset();
        repeat (3) clean_press(1'b1);
        chk("full_pend", 32'(pending), 32'd3);
        for (int i = 1; i <= 6; i++) step(1'b1, (i == 6) ? 1'b0 : 1'b1);
        chk("coin_pend", 32'(pending), 32'd3);
        chk("coin_ovf", 32'(overflow), 32'd0);
        chk("coin_pc", 32'(press_count), 32'd4);
        repeat (8) step(1'b0, 1'b1);

        // Overflow while busy, then drain
        repeat (2) clean_press(1'b1);
        chk("ovf_pend", 32'(pending), 32'd3);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_pc", 32'(press_count), 32'd6);
        repeat (12) step(1'b0, 1'b0);
        chk("drain_pend", 32'(pending), 32'd0);
        chk("drain_ovf", 32'(overflow), 32'd1);
        chk("drain_dr", 32'(data_ready), 32'd0);

        // Random button runs and busy windows, with occasional async resets
        do_reset();
        lvl  = 0;
        blen = 0;
        bz   = 1'b0;
        for (int n = 0; n < 300; n++) begin
            lvl = 1 - lvl;
            len = $urandom_range(1, 10);
            for (int k = 0; k < len; k++) begin
                if (blen == 0) begin
                    bz   = ($urandom_range(0, 2) == 0);
                    blen = $urandom_range(1, 12);
                end
                blen--;
                step(lvl[0], bz);
            end
            if ($urandom_range(0, 59) == 0) do_reset();
        end
        repeat (12) step(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
